// File: rtl/spike_recorder_pkg.sv
// Shared types and constants for the spike recorder: default event layout and drop-counter width.
package spike_recorder_pkg;

  localparam int N_DEF      = 24;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [N_DEF-1:0]    dv;
  } spike_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead FIFO of spike events; the head entry is visible whenever not empty.
// A push that cannot be accepted is reported on drop and leaves the contents untouched.
module spike_event_fifo
  import spike_recorder_pkg::*;
#(
  parameter type T     = spike_event_t,
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spike_recorder.sv
// Timestamps spiking integration steps of one neuron core and queues {ts, dv} events for a reader.
// Optional build macro SPIKE_RECORDER_DROP_CNT_EN adds a saturating drop_count output.
module spike_recorder
  import spike_recorder_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = 8,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   apply,
  input  logic                   is_spiking,
  input  logic [N-1:0]           last_dv,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_W-1:0]        ev_ts,
  output logic [N-1:0]           ev_dv,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
`ifdef SPIKE_RECORDER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_count
`endif
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [N-1:0]    dv;
  } event_t;

  logic            apply_d;
  logic [TS_W-1:0] step_cnt;
  logic            push;
  logic            drop;
  logic            empty;
  event_t          push_ev;
  event_t          head;

  // dv is carried as an opaque Q-format word; Q only documents its scaling.
  logic unused_q;
  assign unused_q = (Q > 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      apply_d  <= 1'b0;
      step_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      apply_d <= apply;
      if (apply_d) step_cnt <= step_cnt + 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

  // The core's spike flag and dv belong to the step completing this cycle.
  assign push       = apply_d && is_spiking;
  assign push_ev.ts = step_cnt;
  assign push_ev.dv = last_dv;

  spike_event_fifo #(
    .T     (event_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev_ready),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  assign ev_valid = !empty;
  assign ev_ts    = head.ts;
  assign ev_dv    = head.dv;

`ifdef SPIKE_RECORDER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/spike_recorder.md
# spike_recorder

Timestamps spike events from one 24-bit Izhikevich core and buffers them for a downstream reader. Observes the same `apply` strobe that drives the core plus the core's `is_spiking` and `last_dv` outputs. Counts completed integration steps and pushes one `{timestamp, dv}` event per spiking step into a small show-ahead FIFO. The FIFO drains through a valid/ready handshake. Sits between the neuron core and the spike-routing/readout logic.

## Interface
- `N`, 24, fixed-point word width (matches core)
- `Q`, 8, fractional bits (carried through only, no arithmetic)
- `TS_W`, 16, step-counter/timestamp width
- `DEPTH`, 8, FIFO entries, power of two ≥ 2
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `apply`  in  1  step strobe, identical to the core's `apply`
- `is_spiking`  in  1  core spike flag, valid the cycle after `apply`
- `last_dv`  in  N  core's dv of the completed step
- `ev_valid`  out  1  head event present
- `ev_ready`  in  1  reader accepts head
- `ev_ts`  out  TS_W  head timestamp (step index)
- `ev_dv`  out  N  head dv
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky: an event was dropped
- `drop_count`  out  8  only with `SPIKE_RECORDER_DROP_CNT_EN`

## Operation
- `apply_d` is `apply` registered one cycle; a step is complete on any cycle where `apply_d == 1`.
- Completed step:
  - The current `step_cnt` is the step's timestamp.
  - `step_cnt` increments modulo 2^TS_W; it wraps silently, `0xFFFF -> 0`.
- Push on a completed step with `is_spiking == 1`, using `{step_cnt, last_dv}`.
- Pop when `ev_valid && ev_ready`.
- Show-ahead FIFO:
  - `ev_ts`/`ev_dv` are driven from the head entry whenever `ev_valid == 1`.
  - `ev_ts`/`ev_dv` are don't-care when `ev_valid == 0`.
- Push while full and no pop: the event is dropped, `overflow` sets, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: the pop frees the slot, the push is accepted, and `count` is unchanged with no drop.
- Push while empty with `ev_ready` high: the event is stored; it is not bypassed to the output the same cycle.
- Back-to-back `apply` on every cycle is legal: one push candidate per cycle.
- `ev_ready` while `ev_valid == 0` is ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is tracked with a separate counter.

## Timing
- Reset values: `ev_valid` 0, `count` 0, `full` 0, `overflow` 0, `drop_count` 0, `step_cnt` 0, `apply_d` 0, pointers 0.
- Reset clears all FIFO contents logically.
- Reset mid-operation:
  - Events held in the FIFO are discarded.
  - An `is_spiking` that appears in the cycle after reset deasserts is ignored, because `apply_d` was cleared.
- Latency from `apply` at cycle t with a resulting spike:
  - `is_spiking` is high at t+1.
  - The event is written at the end of t+1.
  - `ev_valid` is high at t+2.
- A pop at edge k updates `ev_valid`, the outputs and `count` from k+1 onward.
- `overflow` stays set until `rst`.

## Configuration
- `SPIKE_RECORDER_DROP_CNT_EN` defined:
  - Adds the `drop_count` port.
  - `drop_count` increments by one per dropped event and saturates at 255.
  - It clears only on `rst`.
- Not defined: the `drop_count` port and its logic are absent; `overflow` alone reports loss.

## Structure
- `spike_recorder_pkg`:
  - packed struct typedef `spike_event_t {ts, dv}` parameterised via package localparams for the defaults `N=24`, `TS_W=16`
  - localparam `DROP_CNT_W=8`
- One sub-module, `spike_event_fifo`: a synchronous show-ahead FIFO of `spike_event_t`. It provides push/pop, `count`/`full`/empty and a drop indication.
- The top level holds `apply_d`, `step_cnt`, the push qualification and `overflow`/`drop_count`.

## Test plan
- Single spike: after `rst`, pulse `apply` 5 times with `is_spiking` high only after the 3rd pulse and `last_dv=24'h000180`. Required:
  - `ev_valid` rises 2 cycles after the 3rd `apply`, with `ev_ts=2` and `ev_dv=24'h000180`.
  - With `ev_ready=1` it pops and `count` returns to 0.
- Fill and drop: `ev_ready=0` with 10 spiking steps at `DEPTH=8`. Required:
  - `full=1` and `overflow=1`.
  - `drop_count=2` when the macro is defined.
  - Draining yields `ts` 0..7 in order.
- Full with simultaneous push/pop: when full, assert `ev_ready` on the same cycle as a spiking step push. Required: `count` stays 8, no drop, and the new event is last out.
- Timestamp wrap: `TS_W=4`, 17 steps, spike on steps 15 and 16. Required: events `ts=15` then `ts=0`.
- Reset mid-stream: with 3 events queued, assert `rst` for 1 cycle, coinciding with an `apply`/spike pair. Required:
  - `ev_valid=0`, `count=0`, `overflow=0`.
  - The next spike is recorded with `ts=0`.
- Non-spiking steps: 20 `apply` pulses with `is_spiking=0`. Required: no events, then a spike produces `ts=20`.
